// File: rtl/fpu_float_div_sequencer_pkg.sv
// Shared FPU types used by the divide sequencer, the operand classifier
// and the downstream rounder.
package fpu_float_div_sequencer_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fpu_float_t;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic is_norm;
  } fpu_float_conditions_t;

  typedef enum logic [1:0] {
    FPU_RNE = 2'd0,
    FPU_RTZ = 2'd1,
    FPU_RUP = 2'd2,
    FPU_RDN = 2'd3
  } fpu_round_mode_t;

  typedef struct packed {
    logic [1:0] guard;
    logic       sticky;
  } fpu_guard_bits_t;

  typedef enum logic [1:0] {
    DIV_IDLE      = 2'd0,
    DIV_DIVIDE    = 2'd1,
    DIV_NORMALIZE = 2'd2,
    DIV_DONE      = 2'd3
  } fpu_div_state_t;

  typedef struct packed {
    fpu_float_t      a;
    fpu_float_t      b;
    fpu_round_mode_t round_mode;
  } fpu_div_request_t;

  typedef struct packed {
    logic              sign;
    logic signed [9:0] exponent;
    logic [23:0]       significand;
    fpu_guard_bits_t   guard;
  } fpu_float_unrounded_t;

  localparam logic [31:0] FPU_FLOAT_NAN  = 32'hFFFF_FFFF;
  localparam logic [9:0]  FPU_EXP_BIAS   = 10'd127;
  // 27 quotient bits: 24 significand bits, two guard bits and one extra
  // bit absorbed by the normalize step when the ratio is below 1.
  localparam logic [4:0]  DIV_LAST_COUNT = 5'd26;

  // Encoded special result; the caller has already decided which class applies.
  function automatic logic [31:0] fpu_div_special_result(input logic is_nan,
                                                         input logic is_inf,
                                                         input logic sign);
    if (is_nan)      return FPU_FLOAT_NAN;
    else if (is_inf) return {sign, 8'hFF, 23'h0};
    else             return {sign, 31'h0};
  endfunction

endpackage

// File: rtl/fpu_float_div_sequencer_classify.sv
// Combinational single-precision operand classifier. Denormals read as zero.
module fpu_float_classify
  import fpu_float_div_sequencer_pkg::*;
(
  input  fpu_float_t            i_value,
  output fpu_float_conditions_t o_cond
);

  logic w_exp_max;
  logic w_exp_min;
  logic w_man_zero;

  assign w_exp_max  = (i_value.exponent == 8'hFF);
  assign w_exp_min  = (i_value.exponent == 8'h00);
  assign w_man_zero = (i_value.mantissa == 23'h0);

  // Exactly one condition bit is set for any input pattern.
  always_comb begin
    o_cond.is_nan  = w_exp_max && !w_man_zero;
    o_cond.is_inf  = w_exp_max &&  w_man_zero;
    o_cond.is_zero = w_exp_min;
    o_cond.is_norm = !w_exp_max && !w_exp_min;
  end

endmodule

// File: rtl/fpu_float_div_sequencer.sv
// Iterative radix-2 restoring single-precision divider sequencer. Produces an
// unrounded sign/exponent/significand plus guard bits, or a final special
// result that the rounder passes through untouched.
module fpu_float_div_sequencer
  import fpu_float_div_sequencer_pkg::*;
#(
  parameter int TAG_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [31:0]          i_in_a,
  input  logic [31:0]          i_in_b,
  input  logic [1:0]           i_in_round_mode,
  input  logic [TAG_WIDTH-1:0] i_in_tag,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic                 o_out_special,
  output logic [31:0]          o_out_result,
  output logic                 o_out_sign,
  output logic [9:0]           o_out_exponent,
  output logic [23:0]          o_out_mantissa,
  output logic [2:0]           o_out_guard,
  output logic [1:0]           o_out_round_mode,
  output logic [TAG_WIDTH-1:0] o_out_tag
);

  fpu_div_state_t        r_state;
  fpu_div_state_t        w_state_next;
  logic [4:0]            r_count;
  logic [24:0]           r_rem;
  logic [23:0]           r_mb;
  logic [26:0]           r_quo;
  logic [9:0]            r_exp;

  fpu_float_unrounded_t  r_unr;
  logic                  r_out_special;
  logic [31:0]           r_out_result;
  fpu_round_mode_t       r_out_round_mode;
  logic [TAG_WIDTH-1:0]  r_out_tag;

  fpu_div_request_t      w_req;
  fpu_float_conditions_t w_cond_a;
  fpu_float_conditions_t w_cond_b;
  logic                  w_accept;
  logic                  w_sign;
  logic                  w_res_nan;
  logic                  w_res_inf;
  logic                  w_res_zero;
  logic                  w_special;
  logic [9:0]            w_exp_init;
  logic                  w_ge;
  logic [24:0]           w_diff;
  logic [24:0]           w_rem_step;
  logic [26:0]           w_quo_step;
  fpu_float_unrounded_t  w_norm;

  assign w_req = '{a: fpu_float_t'(i_in_a),
                   b: fpu_float_t'(i_in_b),
                   round_mode: fpu_round_mode_t'(i_in_round_mode)};

  fpu_float_classify u_classify_a (.i_value(w_req.a), .o_cond(w_cond_a));
  fpu_float_classify u_classify_b (.i_value(w_req.b), .o_cond(w_cond_b));

  assign o_in_ready = (r_state == DIV_IDLE);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_sign     = w_req.a.sign ^ w_req.b.sign;

  // NaN outranks inf, which outranks zero.
  assign w_res_nan  = w_cond_a.is_nan || w_cond_b.is_nan ||
                      (w_cond_a.is_zero && w_cond_b.is_zero) ||
                      (w_cond_a.is_inf  && w_cond_b.is_inf);
  assign w_res_inf  = !w_res_nan && (w_cond_a.is_inf || w_cond_b.is_zero);
  assign w_res_zero = !w_res_nan && !w_res_inf &&
                      (w_cond_a.is_zero || w_cond_b.is_inf);
  assign w_special  = w_res_nan || w_res_inf || w_res_zero;

  assign w_exp_init = {2'b00, w_req.a.exponent} - {2'b00, w_req.b.exponent}
                      + FPU_EXP_BIAS;

  // One restoring step. The partial remainder stays below 2*mb, so the
  // shifted-out MSB is always zero.
  assign w_ge       = (r_rem >= {1'b0, r_mb});
  assign w_diff     = r_rem - {1'b0, r_mb};
  assign w_rem_step = w_ge ? {w_diff[23:0], 1'b0} : {r_rem[23:0], 1'b0};
  assign w_quo_step = {r_quo[25:0], w_ge};

  // Normalize the 27-bit quotient whose leading one sits at bit 26 or 25.
  always_comb begin
    w_norm.sign = r_unr.sign;
    if (r_quo[26]) begin
      w_norm.exponent     = r_exp;
      w_norm.significand  = r_quo[26:3];
      w_norm.guard.guard  = r_quo[2:1];
      w_norm.guard.sticky = r_quo[0] | (r_rem != 25'h0);
    end else begin
      w_norm.exponent     = r_exp - 10'sd1;
      w_norm.significand  = r_quo[25:2];
      w_norm.guard.guard  = r_quo[1:0];
      w_norm.guard.sticky = (r_rem != 25'h0);
    end
  end

  // Next-state decode; flush wins over every other event.
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE:      if (w_accept) w_state_next = w_special ? DIV_DONE : DIV_DIVIDE;
        DIV_DIVIDE:    if (r_count == 5'd0) w_state_next = DIV_NORMALIZE;
        DIV_NORMALIZE: w_state_next = DIV_DONE;
        DIV_DONE:      if (i_out_ready) w_state_next = DIV_IDLE;
        default:       w_state_next = DIV_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= DIV_IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath and output registers: load on accept, iterate, then normalize.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count          <= 5'd0;
      r_rem            <= 25'h0;
      r_mb             <= 24'h0;
      r_quo            <= 27'h0;
      r_exp            <= 10'h0;
      r_unr            <= '0;
      r_out_special    <= 1'b0;
      r_out_result     <= 32'h0;
      r_out_round_mode <= FPU_RNE;
      r_out_tag        <= '0;
    end else if (!i_flush) begin
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_out_round_mode <= w_req.round_mode;
            r_out_tag        <= i_in_tag;
            r_unr            <= '{sign: w_sign, exponent: 10'sd0,
                                  significand: 24'h0, guard: '0};
            r_out_special    <= w_special;
            r_out_result     <= w_special ?
                                fpu_div_special_result(w_res_nan, w_res_inf, w_sign) :
                                32'h0;
            r_rem            <= {2'b01, w_req.a.mantissa};
            r_mb             <= {1'b1, w_req.b.mantissa};
            r_quo            <= 27'h0;
            r_exp            <= w_exp_init;
            r_count          <= DIV_LAST_COUNT;
          end
        end
        DIV_DIVIDE: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          if (r_count != 5'd0) r_count <= r_count - 5'd1;
        end
        DIV_NORMALIZE: r_unr <= w_norm;
        default: ;
      endcase
    end
  end

  assign o_out_valid      = (r_state == DIV_DONE);
  assign o_out_special    = r_out_special;
  assign o_out_result     = r_out_result;
  assign o_out_sign       = r_unr.sign;
  assign o_out_exponent   = r_unr.exponent;
  assign o_out_mantissa   = r_unr.significand;
  assign o_out_guard      = r_unr.guard;
  assign o_out_round_mode = r_out_round_mode;
  assign o_out_tag        = r_out_tag;

endmodule

// File: tb/tb_fpu_float_div_sequencer.sv
// Directed bench for the divide sequencer with an expected-result queue.
module tb_fpu_float_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_rm;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready, out_special, out_sign;
  logic [31:0] out_result;
  logic [9:0]  out_exponent;
  logic [23:0] out_mantissa;
  logic [2:0]  out_guard;
  logic [1:0]  out_rm;
  logic [3:0]  out_tag;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        special;
    logic [31:0] result;
    logic        sign;
    logic [9:0]  exponent;
    logic [23:0] mant;
    logic [2:0]  guard;
    logic [1:0]  rm;
    logic [3:0]  tag;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fpu_float_div_sequencer #(.TAG_WIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_a(in_a), .i_in_b(in_b), .i_in_round_mode(in_rm), .i_in_tag(in_tag),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_special(out_special), .o_out_result(out_result),
    .o_out_sign(out_sign), .o_out_exponent(out_exponent),
    .o_out_mantissa(out_mantissa), .o_out_guard(out_guard),
    .o_out_round_mode(out_rm), .o_out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, wait for its result, compare against the queue head,
  // optionally hold backpressure for 'hold' cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        input logic [3:0] tag, input logic sp, input logic [31:0] res,
                        input logic [9:0] e, input logic [23:0] m, input logic [2:0] g,
                        input int lat, input int hold);
    exp_t x;
    exp_t y;
    int   cyc;
    x.special = sp; x.result = res; x.sign = a[31] ^ b[31];
    x.exponent = e; x.mant = m; x.guard = g; x.rm = rm; x.tag = tag; x.lat = lat;
    sb.push_back(x);
    out_ready = (hold == 0);
    in_a = a; in_b = b; in_rm = rm; in_tag = tag; in_valid = 1'b1;
    chk("ready_before_accept", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    y = sb.pop_front();
    chk("latency", 64'(cyc), 64'(y.lat));
    chk("special", 64'(out_special), 64'(y.special));
    chk("result", 64'(out_result), 64'(y.result));
    chk("sign", 64'(out_sign), 64'(y.sign));
    chk("exponent", 64'(out_exponent), 64'(y.exponent));
    chk("mantissa", 64'(out_mantissa), 64'(y.mant));
    chk("guard", 64'(out_guard), 64'(y.guard));
    chk("round_mode", 64'(out_rm), 64'(y.rm));
    chk("tag", 64'(out_tag), 64'(y.tag));
    $display("txn a=%h b=%h tag=%0d -> valid@%0d special=%0b result=%h exp=%0d mant=%h guard=%b",
             a, b, tag, cyc, out_special, out_result, out_exponent, out_mantissa, out_guard);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_mantissa", 64'(out_mantissa), 64'(y.mant));
      chk("hold_tag", 64'(out_tag), 64'(y.tag));
    end
    out_ready = 1'b1;
    tick();
    chk("post_handshake_valid", 64'(out_valid), 64'd0);
    chk("post_handshake_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_rm = '0; in_tag = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_mantissa", 64'(out_mantissa), 64'd0);

    // Normal divisions
    run_op(32'h40C00000, 32'h40000000, 2'd1, 4'd1, 1'b0, 32'h0, 10'd128, 24'hC00000, 3'b000, 29, 0);
    run_op(32'h3F800000, 32'h40400000, 2'd2, 4'd2, 1'b0, 32'h0, 10'd125, 24'hAAAAAA, 3'b101, 29, 0);
    run_op(32'hC0C00000, 32'h40000000, 2'd3, 4'd3, 1'b0, 32'h0, 10'd128, 24'hC00000, 3'b000, 29, 0);
    run_op(32'h3F800000, 32'h3F800000, 2'd0, 4'd4, 1'b0, 32'h0, 10'd127, 24'h800000, 3'b000, 29, 0);

    // Special cases
    run_op(32'h3F800000, 32'h00000000, 2'd0, 4'd5, 1'b1, 32'h7F800000, 10'd0, 24'h0, 3'b000, 1, 0);
    run_op(32'h00000000, 32'h00000000, 2'd1, 4'd6, 1'b1, 32'hFFFFFFFF, 10'd0, 24'h0, 3'b000, 1, 0);
    run_op(32'hBF800000, 32'h7F800000, 2'd2, 4'd7, 1'b1, 32'h80000000, 10'd0, 24'h0, 3'b000, 1, 0);
    run_op(32'h7FC00000, 32'h3F800000, 2'd3, 4'd8, 1'b1, 32'hFFFFFFFF, 10'd0, 24'h0, 3'b000, 1, 0);
    run_op(32'h7F800000, 32'h7F800000, 2'd0, 4'd9, 1'b1, 32'hFFFFFFFF, 10'd0, 24'h0, 3'b000, 1, 0);
    run_op(32'h00400000, 32'h40000000, 2'd0, 4'd10, 1'b1, 32'h00000000, 10'd0, 24'h0, 3'b000, 1, 0);

    // Backpressure on a normal result
    run_op(32'h3F800000, 32'h40400000, 2'd1, 4'd11, 1'b0, 32'h0, 10'd125, 24'hAAAAAA, 3'b101, 29, 10);

    // Flush mid-division
    in_a = 32'h40C00000; in_b = 32'h40000000; in_tag = 4'd12; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("flush_busy", 64'(in_ready), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        if (out_valid) seen++;
        tick();
      end
      chk("flush_no_output", 64'(seen), 64'd0);
    end
    $display("txn flush at T0+10 tag=12 -> dropped");
    run_op(32'h3F800000, 32'h40400000, 2'd0, 4'd13, 1'b0, 32'h0, 10'd125, 24'hAAAAAA, 3'b101, 29, 0);

    // Asynchronous reset mid-division; previous outputs are nonzero
    in_a = 32'h40C00000; in_b = 32'h40000000; in_tag = 4'd14; in_rm = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("rst_busy", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_exponent", 64'(out_exponent), 64'd0);
    chk("rst_async_mantissa", 64'(out_mantissa), 64'd0);
    chk("rst_async_guard", 64'(out_guard), 64'd0);
    chk("rst_async_tag", 64'(out_tag), 64'd0);
    chk("rst_async_rm", 64'(out_rm), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_release_ready", 64'(in_ready), 64'd1);
    chk("rst_release_valid", 64'(out_valid), 64'd0);
    $display("txn reset at T0+15 tag=14 -> dropped");
    run_op(32'h40C00000, 32'h40000000, 2'd2, 4'd15, 1'b0, 32'h0, 10'd128, 24'hC00000, 3'b000, 29, 0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
